// File: rtl/dmem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl_pkg
// Brief    : Shared state encodings and bus size codes for the data-memory
//            access controller.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_access_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } dmem_state_e;

  localparam logic [1:0] MEM_SIZE_B = 2'd0;
  localparam logic [1:0] MEM_SIZE_H = 2'd1;
  localparam logic [1:0] MEM_SIZE_W = 2'd2;

endpackage
`default_nettype wire

// File: rtl/dmem_wbuf_tracker.sv
`default_nettype none
// ============================================================================
// Module   : dmem_wbuf_tracker
// Brief    : Outstanding posted-write flag. Set when a store is retired on its
//            address phase, cleared by the bus data phase; while set, new
//            accesses are blocked and a pending MEM request is stalled.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_wbuf_tracker (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic data_ok_i,
  input  logic want_i,
  output logic block_o,
  output logic stall_o
);

  logic pending_q;
  logic pending_d;

  // Set and clear never coincide: a store whose data phase completes with
  // its address phase is never posted.
  always_comb begin
    pending_d = pending_q;
    if (set_i) begin
      pending_d = 1'b1;
    end else if (data_ok_i) begin
      pending_d = 1'b0;
    end
  end

  // Flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign block_o = pending_q;
  assign stall_o = pending_q & want_i;

endmodule
`default_nettype wire

// File: rtl/dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_ctrl
// Brief    : Sequences MEM-stage loads/stores onto an SRAM-like bus
//            (req / addr_ok / data_ok), stalls the pipeline while an access is
//            in flight and drains any accepted transaction whose instruction
//            was flushed.
// Config   : DMEM_CTRL_POSTED_WRITE_EN - stores retire on addr_ok; the open
//            data phase is tracked by dmem_wbuf_tracker.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_ctrl
  import dmem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [1:0]        mem_size_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic              exception_flag_i,
  input  logic              flush_i,
  output logic              stall_req_o,
  output logic              mem_done_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              data_req_o,
  output logic              data_wr_o,
  output logic [1:0]        data_size_o,
  output logic [ADDR_W-1:0] data_addr_o,
  output logic [3:0]        data_wstrb_o,
  output logic [DATA_W-1:0] data_wdata_o,
  input  logic              data_addr_ok_i,
  input  logic              data_data_ok_i,
  input  logic [DATA_W-1:0] data_rdata_i
);

  dmem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              we_q, we_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              kill_q, kill_d;

  logic want;
  logic launch;
  logic cancel;
  logic wb_block;
  logic wb_stall;

  // A request that would be accepted if no posted write were outstanding.
  assign want   = !rst && mem_req_i && !exception_flag_i && !flush_i;
  assign launch = want && !wb_block;
  // A flush seen at any point during REQ cancels completion to the pipeline.
  assign cancel = flush_i || kill_q;

`ifdef DMEM_CTRL_POSTED_WRITE_EN
  logic wb_set;

  dmem_wbuf_tracker u_wbuf (
    .clk       (clk),
    .rst       (rst),
    .set_i     (wb_set),
    .data_ok_i (data_data_ok_i),
    .want_i    (want),
    .block_o   (wb_block),
    .stall_o   (wb_stall)
  );
`else
  assign wb_block = 1'b0;
  assign wb_stall = 1'b0;
`endif

  // Next-state, latch and pipeline-handshake decode.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    size_d      = size_q;
    we_d        = we_q;
    sel_d       = sel_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    kill_d      = kill_q;
    stall_req_o = 1'b0;
    mem_done_o  = 1'b0;
`ifdef DMEM_CTRL_POSTED_WRITE_EN
    wb_set      = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          // Loads latch zero strobes/data so the bus write fields stay 0.
          addr_d      = mem_addr_i;
          size_d      = mem_size_i;
          we_d        = mem_we_i;
          sel_d       = mem_we_i ? mem_sel_i : 4'b0000;
          wdata_d     = mem_we_i ? mem_wdata_i : '0;
          kill_d      = 1'b0;
          stall_req_o = 1'b1;
          state_d     = ST_REQ;
        end else if (wb_stall) begin
          stall_req_o = 1'b1;
        end
      end
      ST_REQ: begin
        stall_req_o = 1'b1;
        if (data_addr_ok_i) begin
          kill_d = 1'b0;
          if (data_data_ok_i) begin
            if (!cancel && !we_q) begin
              rdata_d = data_rdata_i;
            end
            state_d = cancel ? ST_IDLE : ST_DONE;
          end
`ifdef DMEM_CTRL_POSTED_WRITE_EN
          else if (we_q) begin
            // The write is committed on the bus; a flush cannot recall it.
            wb_set  = 1'b1;
            state_d = cancel ? ST_IDLE : ST_DONE;
          end
`endif
          else begin
            state_d = cancel ? ST_DRAIN : ST_WAIT;
          end
        end else if (flush_i) begin
          // The request cannot be withdrawn; remember to drain it.
          kill_d = 1'b1;
        end
      end
      ST_WAIT: begin
        stall_req_o = 1'b1;
        if (data_data_ok_i) begin
          if (!flush_i && !we_q) begin
            rdata_d = data_rdata_i;
          end
          state_d = flush_i ? ST_IDLE : ST_DONE;
        end else if (flush_i) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        mem_done_o = !flush_i;
        state_d    = ST_IDLE;
      end
      ST_DRAIN: begin
        stall_req_o = mem_req_i;
        if (data_data_ok_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-field registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      sel_q   <= 4'b0000;
      wdata_q <= '0;
      rdata_q <= '0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      kill_q  <= kill_d;
    end
  end

  assign mem_rdata_o  = rdata_q;
  assign data_req_o   = (state_q == ST_REQ);
  assign data_wr_o    = we_q;
  assign data_size_o  = size_q;
  assign data_addr_o  = addr_q;
  assign data_wstrb_o = sel_q;
  assign data_wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_ctrl
// Brief    : Directed self-checking bench for dmem_access_ctrl. Inputs change
//            just after the falling edge; outputs are sampled 1 time unit
//            later, well away from the rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_ctrl;
  import dmem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_i, mem_we_i, exception_flag_i, flush_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [1:0]  mem_size_i;
  logic [3:0]  mem_sel_i;
  logic        stall_req_o, mem_done_o, data_req_o, data_wr_o;
  logic [31:0] mem_rdata_o, data_addr_o, data_wdata_o, data_rdata_i;
  logic [1:0]  data_size_o;
  logic [3:0]  data_wstrb_o;
  logic        data_addr_ok_i, data_data_ok_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i),
    .mem_size_i(mem_size_i), .mem_sel_i(mem_sel_i), .mem_wdata_i(mem_wdata_i),
    .exception_flag_i(exception_flag_i), .flush_i(flush_i),
    .stall_req_o(stall_req_o), .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .data_req_o(data_req_o), .data_wr_o(data_wr_o), .data_size_o(data_size_o),
    .data_addr_o(data_addr_o), .data_wstrb_o(data_wstrb_o), .data_wdata_o(data_wdata_o),
    .data_addr_ok_i(data_addr_ok_i), .data_data_ok_i(data_data_ok_i),
    .data_rdata_i(data_rdata_i)
  );

  task automatic quiet();
    mem_req_i = 0; mem_we_i = 0; mem_addr_i = 0; mem_size_i = 0; mem_sel_i = 0;
    mem_wdata_i = 0; exception_flag_i = 0; flush_i = 0;
    data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0;
  endtask

  task automatic test_reset();
    quiet(); rst = 1; mem_req_i = 1; mem_addr_i = 32'h1234_5678;
    @(negedge clk); @(negedge clk); #1;
    total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", stall_req_o); end
    total++; if (data_req_o !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", data_req_o); end
    total++; if (mem_done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", mem_done_o); end
    total++; if (data_addr_o !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h want=0", data_addr_o); end
    total++; if (mem_rdata_o !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%h want=0", mem_rdata_o); end
    total++; if (data_wr_o !== 1'b0 || data_wstrb_o !== 4'h0 || data_size_o !== 2'd0) begin bad++; $display("FAIL rst_wfields got wr=%b strb=%h size=%0d want 0", data_wr_o, data_wstrb_o, data_size_o); end
    @(negedge clk); mem_req_i = 0; mem_addr_i = 0; rst = 0; #1;
    total++; if (stall_req_o !== 1'b0 || data_req_o !== 1'b0) begin bad++; $display("FAIL rst_release got stall=%b req=%b want 0/0", stall_req_o, data_req_o); end
  endtask

  task automatic test_load_word();
    @(negedge clk); mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h8000_0010; mem_size_i = MEM_SIZE_W; mem_sel_i = 4'hF; #1;
    total++; if (stall_req_o !== 1'b1 || data_req_o !== 1'b0) begin bad++; $display("FAIL lw_c0 got stall=%b req=%b want 1/0", stall_req_o, data_req_o); end
    @(negedge clk); data_addr_ok_i = 1; #1;
    total++; if (data_req_o !== 1'b1 || stall_req_o !== 1'b1) begin bad++; $display("FAIL lw_c1 got req=%b stall=%b want 1/1", data_req_o, stall_req_o); end
    total++; if (data_addr_o !== 32'h8000_0010 || data_size_o !== 2'd2) begin bad++; $display("FAIL lw_c1_fields got addr=%h size=%0d want 80000010/2", data_addr_o, data_size_o); end
    total++; if (data_wr_o !== 1'b0 || data_wstrb_o !== 4'h0 || data_wdata_o !== 32'h0) begin bad++; $display("FAIL lw_c1_wforce got wr=%b strb=%h wdata=%h want 0", data_wr_o, data_wstrb_o, data_wdata_o); end
    @(negedge clk); data_addr_ok_i = 0; #1;
    total++; if (data_req_o !== 1'b0 || stall_req_o !== 1'b1) begin bad++; $display("FAIL lw_c2 got req=%b stall=%b want 0/1", data_req_o, stall_req_o); end
    @(negedge clk); data_data_ok_i = 1; data_rdata_i = 32'hDEAD_BEEF; #1;
    total++; if (stall_req_o !== 1'b1 || mem_done_o !== 1'b0) begin bad++; $display("FAIL lw_c3 got stall=%b done=%b want 1/0", stall_req_o, mem_done_o); end
    @(negedge clk); data_data_ok_i = 0; data_rdata_i = 0; #1;
    total++; if (mem_done_o !== 1'b1 || stall_req_o !== 1'b0 || data_req_o !== 1'b0) begin bad++; $display("FAIL lw_c4 got done=%b stall=%b req=%b want 1/0/0", mem_done_o, stall_req_o, data_req_o); end
    total++; if (mem_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_rdata got=%h want=deadbeef", mem_rdata_o); end
    @(negedge clk); mem_req_i = 0; #1;
    total++; if (mem_done_o !== 1'b0 || data_req_o !== 1'b0 || mem_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL lw_c5 got done=%b req=%b rdata=%h want 0/0/deadbeef", mem_done_o, data_req_o, mem_rdata_o); end
  endtask

  task automatic test_store_byte();
    @(negedge clk); mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h8000_0003; mem_size_i = MEM_SIZE_B;
    mem_sel_i = 4'b1000; mem_wdata_i = 32'hAA00_0000; #1;
    total++; if (stall_req_o !== 1'b1) begin bad++; $display("FAIL sb_c0_stall got=%b want=1", stall_req_o); end
    @(negedge clk); data_addr_ok_i = 1; data_data_ok_i = 1; #1;
    total++; if (data_req_o !== 1'b1 || data_wr_o !== 1'b1 || data_wstrb_o !== 4'b1000 || data_size_o !== 2'd0) begin bad++; $display("FAIL sb_c1 got req=%b wr=%b strb=%b size=%0d want 1/1/1000/0", data_req_o, data_wr_o, data_wstrb_o, data_size_o); end
    total++; if (data_wdata_o !== 32'hAA00_0000 || data_addr_o !== 32'h8000_0003) begin bad++; $display("FAIL sb_c1_data got wdata=%h addr=%h want aa000000/80000003", data_wdata_o, data_addr_o); end
    @(negedge clk); data_addr_ok_i = 0; data_data_ok_i = 0; #1;
    total++; if (mem_done_o !== 1'b1 || stall_req_o !== 1'b0 || data_req_o !== 1'b0) begin bad++; $display("FAIL sb_c2 got done=%b stall=%b req=%b want 1/0/0", mem_done_o, stall_req_o, data_req_o); end
    @(negedge clk); mem_req_i = 0; mem_we_i = 0; #1;
    total++; if (mem_done_o !== 1'b0 || data_req_o !== 1'b0) begin bad++; $display("FAIL sb_c3 got done=%b req=%b want 0/0", mem_done_o, data_req_o); end
  endtask

  task automatic test_exception();
    @(negedge clk); mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h8000_0001; mem_size_i = MEM_SIZE_W; exception_flag_i = 1; #1;
    total++; if (stall_req_o !== 1'b0 || data_req_o !== 1'b0) begin bad++; $display("FAIL exc_c0 got stall=%b req=%b want 0/0", stall_req_o, data_req_o); end
    @(negedge clk); #1;
    total++; if (data_req_o !== 1'b0) begin bad++; $display("FAIL exc_c1_req got=%b want=0", data_req_o); end
    @(negedge clk); exception_flag_i = 0; flush_i = 1; #1;
    total++; if (stall_req_o !== 1'b0) begin bad++; $display("FAIL flush_idle_stall got=%b want=0", stall_req_o); end
    @(negedge clk); mem_req_i = 0; flush_i = 0; #1;
    total++; if (data_req_o !== 1'b0) begin bad++; $display("FAIL flush_idle_req got=%b want=0", data_req_o); end
  endtask

  task automatic test_flush_wait();
    @(negedge clk); mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h8000_0020; mem_size_i = MEM_SIZE_W; #1;
    @(negedge clk); data_addr_ok_i = 1; #1;
    @(negedge clk); data_addr_ok_i = 0; flush_i = 1; mem_req_i = 0; #1;
    total++; if (stall_req_o !== 1'b1) begin bad++; $display("FAIL fw_wait_stall got=%b want=1", stall_req_o); end
    @(negedge clk); flush_i = 0; #1;
    total++; if (stall_req_o !== 1'b0 || data_req_o !== 1'b0 || mem_done_o !== 1'b0) begin bad++; $display("FAIL fw_drain got stall=%b req=%b done=%b want 0/0/0", stall_req_o, data_req_o, mem_done_o); end
    @(negedge clk); mem_req_i = 1; mem_addr_i = 32'h8000_0040; #1;
    total++; if (stall_req_o !== 1'b1 || data_req_o !== 1'b0) begin bad++; $display("FAIL fw_drain_newreq got stall=%b req=%b want 1/0", stall_req_o, data_req_o); end
    @(negedge clk); data_data_ok_i = 1; data_rdata_i = 32'h1234_5678; #1;
    total++; if (stall_req_o !== 1'b1 || mem_done_o !== 1'b0) begin bad++; $display("FAIL fw_drain_ok got stall=%b done=%b want 1/0", stall_req_o, mem_done_o); end
    @(negedge clk); data_data_ok_i = 0; data_rdata_i = 0; #1;
    total++; if (stall_req_o !== 1'b1 || data_req_o !== 1'b0 || mem_rdata_o !== 32'hDEAD_BEEF) begin bad++; $display("FAIL fw_relaunch got stall=%b req=%b rdata=%h want 1/0/deadbeef", stall_req_o, data_req_o, mem_rdata_o); end
    @(negedge clk); data_addr_ok_i = 1; data_data_ok_i = 1; data_rdata_i = 32'hCAFE_F00D; #1;
    total++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h8000_0040) begin bad++; $display("FAIL fw_req2 got req=%b addr=%h want 1/80000040", data_req_o, data_addr_o); end
    @(negedge clk); data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0; #1;
    total++; if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'hCAFE_F00D) begin bad++; $display("FAIL fw_done2 got done=%b rdata=%h want 1/cafef00d", mem_done_o, mem_rdata_o); end
    @(negedge clk); mem_req_i = 0; #1;
  endtask

  task automatic test_flush_req();
    @(negedge clk); mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h8000_0050; mem_size_i = MEM_SIZE_W; #1;
    @(negedge clk); flush_i = 1; mem_req_i = 0; #1;
    total++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h8000_0050) begin bad++; $display("FAIL fr_c1 got req=%b addr=%h want 1/80000050", data_req_o, data_addr_o); end
    @(negedge clk); flush_i = 0; mem_addr_i = 32'hFFFF_FFFC; #1;
    total++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h8000_0050) begin bad++; $display("FAIL fr_hold got req=%b addr=%h want 1/80000050", data_req_o, data_addr_o); end
    @(negedge clk); data_addr_ok_i = 1; #1;
    total++; if (data_req_o !== 1'b1) begin bad++; $display("FAIL fr_aok_req got=%b want=1", data_req_o); end
    @(negedge clk); data_addr_ok_i = 0; #1;
    total++; if (data_req_o !== 1'b0 || stall_req_o !== 1'b0 || mem_done_o !== 1'b0) begin bad++; $display("FAIL fr_drain got req=%b stall=%b done=%b want 0/0/0", data_req_o, stall_req_o, mem_done_o); end
    @(negedge clk); data_data_ok_i = 1; #1;
    total++; if (data_req_o !== 1'b0 || mem_done_o !== 1'b0) begin bad++; $display("FAIL fr_dok got req=%b done=%b want 0/0", data_req_o, mem_done_o); end
    @(negedge clk); data_data_ok_i = 0; #1;
    total++; if (data_req_o !== 1'b0 || mem_done_o !== 1'b0) begin bad++; $display("FAIL fr_idle got req=%b done=%b want 0/0", data_req_o, mem_done_o); end
  endtask

  task automatic test_flush_edges();
    @(negedge clk); mem_req_i = 1; mem_we_i = 0; mem_addr_i = 32'h8000_0080; mem_size_i = MEM_SIZE_W; #1;
    @(negedge clk); flush_i = 1; mem_req_i = 0; data_addr_ok_i = 1; data_data_ok_i = 1; data_rdata_i = 32'h0BAD_F00D; #1;
    total++; if (data_req_o !== 1'b1) begin bad++; $display("FAIL fe_req got=%b want=1", data_req_o); end
    @(negedge clk); flush_i = 0; data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0; mem_req_i = 1; mem_addr_i = 32'h8000_0090; #1;
    total++; if (mem_done_o !== 1'b0 || stall_req_o !== 1'b1) begin bad++; $display("FAIL fe_idle got done=%b stall=%b want 0/1", mem_done_o, stall_req_o); end
    @(negedge clk); data_addr_ok_i = 1; data_data_ok_i = 1; data_rdata_i = 32'h1357_2468; #1;
    total++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h8000_0090) begin bad++; $display("FAIL fe_req2 got req=%b addr=%h want 1/80000090", data_req_o, data_addr_o); end
    @(negedge clk); data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0; flush_i = 1; #1;
    total++; if (mem_done_o !== 1'b0 || stall_req_o !== 1'b0) begin bad++; $display("FAIL fe_done_flush got done=%b stall=%b want 0/0", mem_done_o, stall_req_o); end
    @(negedge clk); flush_i = 0; mem_req_i = 0; #1;
    total++; if (mem_done_o !== 1'b0 || data_req_o !== 1'b0) begin bad++; $display("FAIL fe_after got done=%b req=%b want 0/0", mem_done_o, data_req_o); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); mem_req_i = 1; mem_we_i = 1; mem_addr_i = 32'h8000_0060; mem_size_i = MEM_SIZE_W;
    mem_sel_i = 4'hF; mem_wdata_i = 32'h1122_3344; #1;
    total++; if (stall_req_o !== 1'b1) begin bad++; $display("FAIL bb_c0_stall got=%b want=1", stall_req_o); end
    @(negedge clk); data_addr_ok_i = 1; #1;
    total++; if (data_req_o !== 1'b1 || data_wr_o !== 1'b1 || data_wdata_o !== 32'h1122_3344) begin bad++; $display("FAIL bb_c1 got req=%b wr=%b wdata=%h want 1/1/11223344", data_req_o, data_wr_o, data_wdata_o); end
    @(negedge clk); data_addr_ok_i = 0; #1;
`ifdef DMEM_CTRL_POSTED_WRITE_EN
    total++; if (mem_done_o !== 1'b1 || stall_req_o !== 1'b0) begin bad++; $display("FAIL bb_posted_done got done=%b stall=%b want 1/0", mem_done_o, stall_req_o); end
    @(negedge clk); mem_we_i = 0; mem_addr_i = 32'h8000_0070; mem_sel_i = 0; mem_wdata_i = 0; #1;
    for (int c = 0; c < 2; c++) begin
      total++; if (stall_req_o !== 1'b1 || data_req_o !== 1'b0) begin bad++; $display("FAIL bb_block%0d got stall=%b req=%b want 1/0", c, stall_req_o, data_req_o); end
      @(negedge clk); #1;
    end
    data_data_ok_i = 1; #1;
    total++; if (stall_req_o !== 1'b1 || data_req_o !== 1'b0) begin bad++; $display("FAIL bb_wdok got stall=%b req=%b want 1/0", stall_req_o, data_req_o); end
    @(negedge clk); data_data_ok_i = 0; #1;
    total++; if (stall_req_o !== 1'b1 || data_req_o !== 1'b0) begin bad++; $display("FAIL bb_launch got stall=%b req=%b want 1/0", stall_req_o, data_req_o); end
`else
    for (int c = 0; c < 3; c++) begin
      total++; if (stall_req_o !== 1'b1 || mem_done_o !== 1'b0 || data_req_o !== 1'b0) begin bad++; $display("FAIL bb_wait%0d got stall=%b done=%b req=%b want 1/0/0", c, stall_req_o, mem_done_o, data_req_o); end
      @(negedge clk); #1;
    end
    data_data_ok_i = 1; #1;
    total++; if (stall_req_o !== 1'b1) begin bad++; $display("FAIL bb_wdok got stall=%b want 1", stall_req_o); end
    @(negedge clk); data_data_ok_i = 0; #1;
    total++; if (mem_done_o !== 1'b1 || stall_req_o !== 1'b0) begin bad++; $display("FAIL bb_sdone got done=%b stall=%b want 1/0", mem_done_o, stall_req_o); end
    @(negedge clk); mem_we_i = 0; mem_addr_i = 32'h8000_0070; mem_sel_i = 0; mem_wdata_i = 0; #1;
    total++; if (stall_req_o !== 1'b1 || data_req_o !== 1'b0) begin bad++; $display("FAIL bb_launch got stall=%b req=%b want 1/0", stall_req_o, data_req_o); end
`endif
    @(negedge clk); data_addr_ok_i = 1; data_data_ok_i = 1; data_rdata_i = 32'h55AA_55AA; #1;
    total++; if (data_req_o !== 1'b1 || data_addr_o !== 32'h8000_0070 || data_wr_o !== 1'b0) begin bad++; $display("FAIL bb_lreq got req=%b addr=%h wr=%b want 1/80000070/0", data_req_o, data_addr_o, data_wr_o); end
    @(negedge clk); data_addr_ok_i = 0; data_data_ok_i = 0; data_rdata_i = 0; #1;
    total++; if (mem_done_o !== 1'b1 || mem_rdata_o !== 32'h55AA_55AA) begin bad++; $display("FAIL bb_ldone got done=%b rdata=%h want 1/55aa55aa", mem_done_o, mem_rdata_o); end
    @(negedge clk); mem_req_i = 0; #1;
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_store_byte();
    test_exception();
    test_flush_wait();
    test_flush_req();
    test_flush_edges();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule
`default_nettype wire
